move_collector: RTL and testbench
=================================

// Module: move_collector
// PURPOSE
//  Reader side of the square move-word interface. Each square drives 32-bit move words
//  (U_move_out..RRD_move_out). This block snapshots a flattened bus of those words on
//  start, scans them in index order, and queues every valid move in a FIFO.
//  The search engine pops moves from the FIFO over a valid/ready stream.
//  Sits between the square array and the move-ordering/search logic.
// PARAMETERS
//  NUM_SRC     32   number of 32-bit move words on move_bus (index 0 = bits [31:0])
//  FIFO_DEPTH  16   output FIFO entries (power of 2, >=2)
//  CNT_W       16   width of move_count
// PORTS
//  clk          in   1              clock, all logic on rising edge
//  clear        in   1              synchronous active-low reset
//  start        in   1              pulse: snapshot move_bus and begin scan (IDLE only)
//  move_bus     in   NUM_SRC*32     concatenated square move words; bit 31 of each word = valid
//  busy         out  1              high from the cycle after accepted start until done
//  done         out  1              one-cycle pulse: scan complete and FIFO drained
//  move_valid   out  1              FIFO head holds a move
//  move_ready   in   1              consumer accepts head when move_valid & move_ready
//  move_data    out  32             FIFO head word (bit 31 always 1 when move_valid)
//  move_count   out  CNT_W          moves pushed since last accepted start, saturating
// BEHAVIOUR
//  Reset (clear=0 at a clk edge)
//   - state=IDLE; busy=0, done=0, move_valid=0, move_data=0, move_count=0.
//   - FIFO emptied, idx=0, snapshot=0. Applies mid-scan: queued moves are discarded.
//  States: IDLE, SCAN, DRAIN, FIN
//   - IDLE: start=1 -> latch move_bus into snapshot, idx=0, move_count=0, go SCAN.
//     FIFO contents left by a prior pass are kept.
//   - SCAN: each cycle examine w=snapshot[idx*32+:32].
//       w[31]=0 -> skip, idx++.
//       w[31]=1 and push_ok -> push w, move_count++ (saturate at all-ones), idx++.
//       w[31]=1 and !push_ok -> stall, idx held.
//       push_ok = (occupancy<FIFO_DEPTH) | (move_valid & move_ready).
//     When idx=NUM_SRC-1 advances -> DRAIN (idx does not wrap).
//   - DRAIN: wait until FIFO occupancy=0 -> FIN.
//   - FIN: done=1 for exactly this cycle -> IDLE.
//  Start handling
//   - start in SCAN/DRAIN/FIN is ignored; no snapshot, no restart.
//   - busy=1 in SCAN and DRAIN; 0 in IDLE and FIN.
//   - Changes on move_bus after the snapshot have no effect on the pass.
//  Latency
//   - start sampled at edge E0 -> SCAN during cycle E0+1.
//   - Valid word at idx0 pushed at edge E1 -> move_valid=1 in cycle after E1.
//   - Minimum start-to-done with no valid words: NUM_SRC+2 cycles.
//  FIFO
//   - First-word-fall-through; move_data/move_valid are registered outputs.
//   - Order = ascending idx.
//   - Simultaneous push and pop when full is allowed; occupancy unchanged.
//   - move_data is stable while move_valid & !move_ready.
//   - Pop with move_valid=0 is a no-op.
//   - Pointers wrap modulo FIFO_DEPTH.
// TESTING
//  1 Reset: clear=0 for 2 cycles mid-SCAN with 3 queued moves -> next cycle move_valid=0,
//    busy=0, move_count=0; a subsequent start runs normally.
//  2 NUM_SRC=32, words idx 3,7,31 = 0x8000_0103/0x8000_0207/0x8000_031F, rest 0,
//    move_ready=1 -> three moves in that order; move_count=3; done at start+34.
//  3 All 32 words valid, FIFO_DEPTH=16, move_ready=0 -> SCAN stalls at idx16 with 16 queued.
//    Raise move_ready -> all 32 emerge in order; done one cycle after the last pop
//    empties the FIFO.
//  4 move_ready toggled 1-0-1 at random -> move_data never changes while valid & !ready;
//    no loss or duplication (scoreboard).
//  5 start pulsed during SCAN and DRAIN with a different move_bus -> ignored; output
//    matches the first snapshot only.
//  6 All words invalid -> no move_valid; done pulses once at start+34; move_count=0.

Source files
------------

// File: rtl/move_collector.sv
// Snapshots the square move-word bus on start, scans it in index order and
// queues every valid move word in a first-word-fall-through FIFO.
module move_collector #(
  parameter int NUM_SRC    = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                   i_clk,
  input  logic                   i_clear,
  input  logic                   i_start,
  input  logic [NUM_SRC*32-1:0]  i_move_bus,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_move_valid,
  input  logic                   i_move_ready,
  output logic [31:0]            o_move_data,
  output logic [CNT_W-1:0]       o_move_count
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SRC - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [31:0]        r_snap [NUM_SRC];
  logic [IDX_W-1:0]   r_idx;

  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [OCC_W-1:0]   r_occ;
  logic               r_moveValid;
  logic [31:0]        r_moveData;
  logic [CNT_W-1:0]   r_moveCount;

  logic [31:0]        w_word;
  logic               w_scanning;
  logic               w_accept;
  logic               w_pop;
  logic               w_pushOk;
  logic               w_push;
  logic               w_advance;
  logic [OCC_W-1:0]   w_occNext;
  logic [PTR_W-1:0]   w_rdPtrNext;
  logic [31:0]        w_headNext;

  // A full FIFO can still take a push when the head leaves on the same edge.
  always_comb begin
    w_word      = r_snap[r_idx];
    w_scanning  = (r_state == S_SCAN);
    w_accept    = (r_state == S_IDLE) && i_start;
    w_pop       = r_moveValid && i_move_ready;
    w_pushOk    = (r_occ < DEPTH_OCC) || w_pop;
    w_push      = w_scanning && w_word[31] && w_pushOk;
    w_advance   = w_scanning && (!w_word[31] || w_pushOk);
    w_occNext   = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    w_rdPtrNext = w_pop ? (r_rdPtr + PTR_W'(1)) : r_rdPtr;
    // An entry written this edge into an otherwise empty FIFO becomes the head directly.
    if (w_push && ((r_occ - OCC_W'(w_pop)) == '0)) begin
      w_headNext = w_word;
    end else begin
      w_headNext = r_mem[w_rdPtrNext];
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nextState = S_SCAN;
        end
      end
      S_SCAN: begin
        o_busy = 1'b1;
        if (w_advance && (r_idx == LAST_IDX)) begin
          w_nextState = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_occNext == '0) begin
          w_nextState = S_FIN;
        end
      end
      S_FIN: begin
        o_done      = 1'b1;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_clear) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_occ       <= '0;
      r_moveValid <= 1'b0;
      r_moveData  <= '0;
      r_moveCount <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        r_snap[i] <= '0;
      end
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          r_snap[i] <= i_move_bus[i*32 +: 32];
        end
        r_idx       <= '0;
        r_moveCount <= '0;
      end else if (w_advance && (r_idx != LAST_IDX)) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
        if (r_moveCount != '1) begin
          r_moveCount <= r_moveCount + CNT_W'(1);
        end
      end
      r_rdPtr     <= w_rdPtrNext;
      r_occ       <= w_occNext;
      r_moveValid <= (w_occNext != '0);
      if (w_occNext != '0) begin
        r_moveData <= w_headNext;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && i_clear) begin
      r_mem[r_wrPtr] <= w_word;
    end
  end

  assign o_move_valid = r_moveValid;
  assign o_move_data  = r_moveData;
  assign o_move_count = r_moveCount;

endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector: a table of scan passes checked against a
// queue of expected move words, plus hand-written reset and back-pressure sequences.
module tb_move_collector;

  localparam int NUM_SRC    = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 16;

  logic                  clk = 1'b0;
  logic                  clear;
  logic                  start;
  logic [NUM_SRC*32-1:0] moveBus;
  logic                  moveReady;
  logic                  busy;
  logic                  done;
  logic                  moveValid;
  logic [31:0]           moveData;
  logic [CNT_W-1:0]      moveCount;

  move_collector #(
    .NUM_SRC    (NUM_SRC),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_clear      (clear),
    .i_start      (start),
    .i_move_bus   (moveBus),
    .o_busy       (busy),
    .o_done       (done),
    .o_move_valid (moveValid),
    .i_move_ready (moveReady),
    .o_move_data  (moveData),
    .o_move_count (moveCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mask;
    logic [7:0]  tag;
    int          mode;
    bit          inj;
    int          expDone;
    int          expCount;
    int          expFirst;
    string       name;
  } vec_t;

  vec_t        vecs [8];
  int          vecCount = 0;
  int          missCount = 0;
  logic [31:0] expQ [$];
  int          cycleNum;
  int          doneCount;
  int          doneAt;
  int          firstValid;
  int          lastPopCycle;
  bit          prevHold;
  logic [31:0] prevData;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] goodWord(input int idx, input int ord, input logic [7:0] tag);
    return {1'b1, 7'h00, tag, 8'(ord), 8'(idx)};
  endfunction

  function automatic logic pickReady(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic applyStimulus(input logic [NUM_SRC*32-1:0] bus, input logic startVal, input logic readyVal);
    moveBus   = bus;
    start     = startVal;
    moveReady = readyVal;
  endtask

  // Invalid words carry junk in the low bits so only bit 31 can gate them.
  task automatic preparePass(input logic [31:0] mask, input logic [7:0] tag, output logic [NUM_SRC*32-1:0] bus);
    int ord;
    ord = 0;
    expQ.delete();
    bus = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mask[i]) begin
        ord++;
        bus[i*32 +: 32] = goodWord(i, ord, tag);
        expQ.push_back(goodWord(i, ord, tag));
      end else begin
        bus[i*32 +: 32] = {1'b0, 7'h55, tag, 8'h00, 8'(i)};
      end
    end
    cycleNum     = 0;
    doneCount    = 0;
    doneAt       = -1;
    firstValid   = -1;
    lastPopCycle = -1;
    prevHold     = 1'b0;
  endtask

  task automatic stepCycle(input logic [NUM_SRC*32-1:0] bus, input logic startVal, input logic readyVal);
    applyStimulus(bus, startVal, readyVal);
    if (prevHold) begin
      checkOutput("hold valid", 64'(moveValid), 64'(1));
      checkOutput("hold data", 64'(moveData), 64'(prevData));
    end
    if (moveValid && firstValid < 0) firstValid = cycleNum;
    if (done) begin
      doneCount++;
      if (doneAt < 0) doneAt = cycleNum;
    end
    if (moveValid && readyVal) begin
      lastPopCycle = cycleNum;
      if (expQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL extra move: got 0x%0h, expected no move", moveData);
      end else begin
        checkOutput("move order", 64'(moveData), 64'(expQ.pop_front()));
      end
    end
    prevHold = moveValid && !readyVal;
    prevData = moveData;
    @(negedge clk);
    cycleNum++;
  endtask

  // Runs one pass from the start pulse to two cycles beyond done.
  task automatic runPass(input vec_t v);
    logic [NUM_SRC*32-1:0] bus;
    logic [NUM_SRC*32-1:0] alt;
    logic                  s;
    preparePass(v.mask, v.tag, bus);
    for (int i = 0; i < NUM_SRC; i++) begin
      alt[i*32 +: 32] = {1'b1, 7'h7F, 8'hEE, 8'h00, 8'(i)};
    end
    while (doneCount == 0 && cycleNum < 400) begin
      s = (cycleNum == 0) || (v.inj && (cycleNum == 10 || cycleNum == 33 || cycleNum == 34));
      stepCycle((v.inj && cycleNum >= 1) ? alt : bus, s, pickReady(v.mode));
    end
    repeat (2) stepCycle(bus, 1'b0, pickReady(v.mode));
    checkOutput({v.name, " done pulses"}, 64'(doneCount), 64'(1));
    if (v.expDone >= 0) checkOutput({v.name, " done cycle"}, 64'(doneAt), 64'(v.expDone));
    checkOutput({v.name, " moves missing"}, 64'(expQ.size()), 64'(0));
    checkOutput({v.name, " move_count"}, 64'(moveCount), 64'(v.expCount));
    checkOutput({v.name, " first valid"}, 64'(firstValid), 64'(v.expFirst));
    checkOutput({v.name, " busy idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [NUM_SRC*32-1:0] bus;

    vecs[0] = '{32'h8000_0088, 8'h00, 0, 1'b0, 34,  3, 5, "sparse"};
    vecs[1] = '{32'h0000_0000, 8'h01, 0, 1'b0, 34,  0, -1, "empty"};
    vecs[2] = '{32'hFFFF_FFFF, 8'h02, 0, 1'b0, 34, 32, 2, "full"};
    vecs[3] = '{32'hAAAA_AAAA, 8'h03, 0, 1'b0, 34, 16, 3, "odd"};
    vecs[4] = '{32'h0000_0001, 8'h04, 0, 1'b0, 34,  1, 2, "idx0"};
    vecs[5] = '{32'h0000_F0F0, 8'h05, 0, 1'b1, 34,  8, 6, "restart"};
    vecs[6] = '{32'h5A5A_5A5A, 8'h06, 1, 1'b0, -1, 16, 3, "randsparse"};
    vecs[7] = '{32'hFFFF_FFFF, 8'h07, 1, 1'b0, -1, 32, 2, "randfull"};

    clear = 1'b0;
    applyStimulus('0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    clear = 1'b1;
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset valid", 64'(moveValid), 64'(0));
    checkOutput("reset data", 64'(moveData), 64'(0));
    checkOutput("reset count", 64'(moveCount), 64'(0));
    @(negedge clk);

    // Clear mid-scan with three moves queued must discard them.
    preparePass(32'hFFFF_FFFF, 8'h11, bus);
    stepCycle(bus, 1'b1, 1'b0);
    repeat (3) stepCycle(bus, 1'b0, 1'b0);
    checkOutput("pre-clear valid", 64'(moveValid), 64'(1));
    checkOutput("pre-clear count", 64'(moveCount), 64'(3));
    clear = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    checkOutput("clear valid", 64'(moveValid), 64'(0));
    checkOutput("clear busy", 64'(busy), 64'(0));
    checkOutput("clear count", 64'(moveCount), 64'(0));
    checkOutput("clear data", 64'(moveData), 64'(0));
    @(negedge clk);
    checkOutput("clear stays idle", 64'(busy), 64'(0));

    for (int v = 0; v < 8; v++) begin
      runPass(vecs[v]);
    end

    // Back-pressure: scan stalls on a full FIFO and resumes once the consumer pops.
    preparePass(32'hFFFF_FFFF, 8'h33, bus);
    stepCycle(bus, 1'b1, 1'b0);
    repeat (39) stepCycle(bus, 1'b0, 1'b0);
    checkOutput("stall count", 64'(moveCount), 64'(16));
    checkOutput("stall busy", 64'(busy), 64'(1));
    checkOutput("stall valid", 64'(moveValid), 64'(1));
    checkOutput("stall head", 64'(moveData), 64'(goodWord(0, 1, 8'h33)));
    checkOutput("stall no done", 64'(doneCount), 64'(0));
    while (doneCount == 0 && cycleNum < 400) stepCycle(bus, 1'b0, 1'b1);
    checkOutput("stall moves missing", 64'(expQ.size()), 64'(0));
    checkOutput("stall done after last pop", 64'(doneAt), 64'(lastPopCycle + 1));
    checkOutput("stall final count", 64'(moveCount), 64'(32));
    stepCycle(bus, 1'b0, 1'b1);
    checkOutput("stall done pulses", 64'(doneCount), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
